// File: rtl/mem_unit_pkg.sv
// rtl/mem_unit_pkg.sv - shared types and constants for the WISC-S15 memory stage
package mem_unit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        reg_write;
        logic        ret;
    } mem_wb_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with synchronous clear
module mem_wb_reg
    import mem_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - memory stage: req/ack data memory FSM, stall, timeout, MEM/WB register
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_to_mem_in,
    input  logic        ret_future_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [3:0]  wb_reg_rd,
    output logic [15:0] wb_data,
    output logic        wb_reg_write,
    output logic        ret_wb,
    output logic [15:0] PC_stack_pointer,
    output logic        mem_err
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    mem_state_t  state, next_state;
    logic [3:0]  cnt;
    logic [15:0] addr_q, wdata_q;
    logic        is_store_q, is_ret_q;
    logic [3:0]  rd_q;
    logic        memop, complete, timeout, stall;
    mem_wb_t     wb_d, wb_q;

    assign memop = valid_in & (mem_to_reg_in | reg_to_mem_in | ret_future_in);

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        wb_d       = '0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall      = 1'b1;
                    next_state = ACCESS;
                end else if (valid_in) begin
                    wb_d.valid     = 1'b1;
                    wb_d.rd        = reg_rd_in;
                    wb_d.data      = alu_result;
                    wb_d.reg_write = 1'b1;
                end
            end
            ACCESS: begin
                // An ack arriving on the timeout cycle still counts as a real completion
                timeout  = !mem_ack && (cnt == TIMEOUT_CNT);
                complete = mem_ack || timeout;
                stall    = !complete;
                if (complete) begin
                    next_state = IDLE;
                    wb_d.valid = 1'b1;
                    wb_d.rd    = rd_q;
                    if (!is_store_q) begin
                        wb_d.data = mem_ack ? mem_rdata : 16'h0000;
                        if (is_ret_q) begin
                            wb_d.ret = 1'b1;
                        end else begin
                            wb_d.reg_write = 1'b1;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            is_store_q <= 1'b0;
            is_ret_q   <= 1'b0;
            rd_q       <= 4'd0;
            mem_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && memop) begin
                addr_q     <= alu_result;
                wdata_q    <= store_data;
                is_store_q <= reg_to_mem_in;
                is_ret_q   <= ret_future_in & ~reg_to_mem_in;
                rd_q       <= reg_rd_in;
                cnt        <= 4'd0;
            end else if (state == ACCESS) begin
                cnt <= complete ? 4'd0 : cnt + 4'd1;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk (clk),
        .rst (rst),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign mem_req          = (state == ACCESS);
    assign mem_we           = (state == ACCESS) & is_store_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign mem_stall        = stall;
    assign wb_valid         = wb_q.valid;
    assign wb_reg_rd        = wb_q.rd;
    assign wb_reg_write     = wb_q.reg_write;
    assign ret_wb           = wb_q.ret;
    // A return's popped address travels in the data field but leaves only via PC_stack_pointer
    assign wb_data          = wb_q.ret ? 16'h0000 : wb_q.data;
    assign PC_stack_pointer = wb_q.ret ? wb_q.data : 16'h0000;

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_to_reg_in, reg_to_mem_in, ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result, store_data, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_stall, wb_valid, wb_reg_write, ret_wb, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data, PC_stack_pointer;
    logic [3:0]  wb_reg_rd;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_unit dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .reg_to_mem_in    (reg_to_mem_in),
        .ret_future_in    (ret_future_in),
        .reg_rd_in        (reg_rd_in),
        .alu_result       (alu_result),
        .store_data       (store_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .mem_stall        (mem_stall),
        .wb_valid         (wb_valid),
        .wb_reg_rd        (wb_reg_rd),
        .wb_data          (wb_data),
        .wb_reg_write     (wb_reg_write),
        .ret_wb           (ret_wb),
        .PC_stack_pointer (PC_stack_pointer),
        .mem_err          (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_in      = 1'b0;
        mem_to_reg_in = 1'b0;
        reg_to_mem_in = 1'b0;
        ret_future_in = 1'b0;
        reg_rd_in     = 4'd0;
        alu_result    = 16'h0000;
        store_data    = 16'h0000;
        mem_rdata     = 16'h0000;
        mem_ack       = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_ret_wb", ret_wb, 0);
        chk("rst_pcsp", PC_stack_pointer, 16'h0000);
        chk("rst_err", mem_err, 0);
        rst = 1'b0;

        // Non-memory op
        valid_in = 1'b1; alu_result = 16'h1234; reg_rd_in = 4'd5;
        #1 chk("alu_stall", mem_stall, 0);
        tick();
        clear_in();
        #1;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_rw", wb_reg_write, 1);
        chk("alu_wb_rd", wb_reg_rd, 5);
        chk("alu_req", mem_req, 0);

        // Load from 0x0040, ack in cycle 3
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0040; reg_rd_in = 4'd3;
        #1 chk("ld_c0_stall", mem_stall, 1);
        chk("ld_c0_req", mem_req, 0);
        tick();
        clear_in();
        #1;
        chk("ld_c1_req", mem_req, 1);
        chk("ld_c1_we", mem_we, 0);
        chk("ld_c1_addr", mem_addr, 16'h0040);
        chk("ld_c1_stall", mem_stall, 1);
        chk("ld_c1_wb_valid", wb_valid, 0);
        tick();
        chk("ld_c2_req", mem_req, 1);
        chk("ld_c2_stall", mem_stall, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1 chk("ld_c3_req", mem_req, 1);
        chk("ld_c3_stall", mem_stall, 0);
        tick();
        clear_in();
        #1;
        chk("ld_c4_wb_valid", wb_valid, 1);
        chk("ld_c4_wb_data", wb_data, 16'hBEEF);
        chk("ld_c4_wb_rd", wb_reg_rd, 3);
        chk("ld_c4_wb_rw", wb_reg_write, 1);
        chk("ld_c4_req", mem_req, 0);

        // Store 0x00AA to 0x0010, ack in cycle 1, then back-to-back load
        valid_in = 1'b1; reg_to_mem_in = 1'b1; alu_result = 16'h0010;
        store_data = 16'h00AA; reg_rd_in = 4'd7;
        tick();
        clear_in();
        mem_ack = 1'b1;
        #1 chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 16'h0010);
        chk("st_wdata", mem_wdata, 16'h00AA);
        chk("st_stall", mem_stall, 0);
        tick();
        clear_in();
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0020; reg_rd_in = 4'd1;
        #1 chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_rw", wb_reg_write, 0);
        chk("st_wb_data", wb_data, 16'h0000);
        chk("b2b_gap_req", mem_req, 0);
        tick();
        clear_in();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        #1 chk("b2b_req", mem_req, 1);
        chk("b2b_addr", mem_addr, 16'h0020);
        tick();
        clear_in();
        #1 chk("b2b_wb_data", wb_data, 16'h7777);

        // Return from SP 0xFFFE
        valid_in = 1'b1; ret_future_in = 1'b1; alu_result = 16'hFFFE; reg_rd_in = 4'd0;
        tick();
        clear_in();
        mem_ack = 1'b1; mem_rdata = 16'h0123;
        #1 chk("ret_addr", mem_addr, 16'hFFFE);
        chk("ret_we", mem_we, 0);
        tick();
        clear_in();
        #1 chk("ret_wb", ret_wb, 1);
        chk("ret_pcsp", PC_stack_pointer, 16'h0123);
        chk("ret_rw", wb_reg_write, 0);
        tick();
        chk("ret_wb_pulse", ret_wb, 0);

        // Ack exactly at count 15: no error
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0050; reg_rd_in = 4'd4;
        tick();
        clear_in();
        for (int i = 0; i < 14; i++) tick();
        chk("ack15_c15_req", mem_req, 1);
        chk("ack15_c15_stall", mem_stall, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        #1 chk("ack15_c16_stall", mem_stall, 0);
        tick();
        clear_in();
        #1 chk("ack15_err", mem_err, 0);
        chk("ack15_wb_data", wb_data, 16'h5A5A);

        // Timeout: no ack
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0060; reg_rd_in = 4'd2;
        tick();
        clear_in();
        for (int i = 0; i < 15; i++) tick();
        chk("to_c16_stall", mem_stall, 0);
        chk("to_c16_err", mem_err, 0);
        tick();
        chk("to_req", mem_req, 0);
        chk("to_err", mem_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_data", wb_data, 16'h0000);
        tick();
        chk("to_err_sticky", mem_err, 1);

        // Reset in the second ACCESS cycle
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0070; reg_rd_in = 4'd9;
        tick();
        clear_in();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("rstacc_req", mem_req, 0);
        chk("rstacc_addr", mem_addr, 16'h0000);
        chk("rstacc_wb_valid", wb_valid, 0);
        chk("rstacc_err", mem_err, 0);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        #1 chk("late_ack_stall", mem_stall, 0);
        tick();
        clear_in();
        #1 chk("late_ack_wb_valid", wb_valid, 0);
        chk("late_ack_wb_data", wb_data, 16'h0000);
        chk("late_ack_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
